// File: rtl/addsub_pkg.sv
// Shared types and constants for the pipelined add/subtract unit.
package addsub_pkg;

    // Widest WIDTH the saturation constant helpers can build.
    localparam int MAX_W = 64;

    // Per-slice control payload that travels with each operation.
    // a_msb / b_msb hold the sign bits of a and of the effective b (b ^ sub),
    // captured at issue so the final stage can evaluate signed overflow.
    typedef struct packed {
        logic valid;
        logic sub;
        logic sat;
        logic carry;
        logic a_msb;
        logic b_msb;
    } slice_ctl_t;

    // Number of bits handled by each register slice.
    function automatic int chunk_w(input int width, input int stages);
        return width / stages;
    endfunction

    // Largest signed value of a width-bit word: 0111..1.
    function automatic logic [MAX_W-1:0] sat_max(input int width);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < width - 1) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    // Smallest signed value of a width-bit word: 1000..0.
    function automatic logic [MAX_W-1:0] sat_min(input int width);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i == width - 1) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// One CHUNK-bit slice of the carry-chained adder. Slice K adds bits
// [K*CHUNK +: CHUNK] of a and the effective b, using the carry left by the
// previous slice, and registers the partial result together with the
// remaining operands, the carry out and the control payload.
module addsub_slice
    import addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int TAG_W = 4,
    parameter int K     = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             flush,
    input  slice_ctl_t       ctl_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] res_in,
    input  logic [TAG_W-1:0] tag_in,
    output slice_ctl_t       ctl_out,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic [WIDTH-1:0] res_out,
    output logic [TAG_W-1:0] tag_out
);

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   sum;
    logic [WIDTH-1:0] res_nxt;

    logic             valid_q;
    logic             sub_q;
    logic             sat_q;
    logic             carry_q;
    logic             a_msb_q;
    logic             b_msb_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [TAG_W-1:0] tag_q;

    // Subtraction inverts this chunk of b; the +1 enters as slice 0's carry-in.
    assign a_chunk = a_in[K*CHUNK +: CHUNK];
    assign b_chunk = b_in[K*CHUNK +: CHUNK] ^ {CHUNK{ctl_in.sub}};
    assign sum     = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, ctl_in.carry};

    // Merge this slice's sum bits into the partial result built so far.
    always_comb begin
        res_nxt                    = res_in;
        res_nxt[K*CHUNK +: CHUNK]  = sum[CHUNK-1:0];
    end

    // Slot occupancy: cleared by reset or flush, otherwise shifts on enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (en) begin
            valid_q <= ctl_in.valid;
        end
    end

    // Data payload is only captured on enable and needs no reset.
    always_ff @(posedge clk) begin
        if (en) begin
            sub_q   <= ctl_in.sub;
            sat_q   <= ctl_in.sat;
            carry_q <= sum[CHUNK];
            a_msb_q <= ctl_in.a_msb;
            b_msb_q <= ctl_in.b_msb;
            a_q     <= a_in;
            b_q     <= b_in;
            res_q   <= res_nxt;
            tag_q   <= tag_in;
        end
    end

    // Repack the registered fields for the next slice.
    always_comb begin
        ctl_out       = '0;
        ctl_out.valid = valid_q;
        ctl_out.sub   = sub_q;
        ctl_out.sat   = sat_q;
        ctl_out.carry = carry_q;
        ctl_out.a_msb = a_msb_q;
        ctl_out.b_msb = b_msb_q;
    end

    assign a_out   = a_q;
    assign b_out   = b_q;
    assign res_out = res_q;
    assign tag_out = tag_q;

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined integer add/subtract unit with valid/ready handshake.
// STAGES slices each add WIDTH/STAGES bits; the last slice's registers are
// the output stage, so latency equals STAGES. Flags and saturation are
// derived from that final register. A single global advance signal moves
// every slice at once, so a stalled output freezes the whole pipe.
// WIDTH must be a multiple of STAGES and no wider than addsub_pkg::MAX_W.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             sat,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             carry,
    output logic             zero,
    output logic             neg,
    output logic [TAG_W-1:0] out_tag
);

    localparam int               CHUNK       = chunk_w(WIDTH, STAGES);
    localparam logic [MAX_W-1:0] SAT_MAX_FULL = sat_max(WIDTH);
    localparam logic [MAX_W-1:0] SAT_MIN_FULL = sat_min(WIDTH);
    localparam logic [WIDTH-1:0] SAT_MAX      = SAT_MAX_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SAT_MIN      = SAT_MIN_FULL[WIDTH-1:0];

    // Clamp toward the sign of a when the raw result overflowed.
    function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] raw,
                                                  input logic             clamp,
                                                  input logic             a_sign);
        if (!clamp) begin
            return raw;
        end
        return a_sign ? SAT_MIN : SAT_MAX;
    endfunction

    // Index k is the input of slice k; index STAGES is the output stage.
    slice_ctl_t       ctl_p [0:STAGES];
    logic [WIDTH-1:0] a_p   [0:STAGES];
    logic [WIDTH-1:0] b_p   [0:STAGES];
    logic [WIDTH-1:0] res_p [0:STAGES];
    logic [TAG_W-1:0] tag_p [0:STAGES];

    logic             adv;
    logic             accept;
    slice_ctl_t       fin;
    logic [WIDTH-1:0] raw;
    logic             ovf_raw;
    logic [WIDTH-1:0] res_sat;

    // Handshake: the pipe moves whenever the output slot is empty or drained.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv && !flush;
    assign accept   = in_valid && in_ready;

    // Issue: build the payload entering slice 0; sub doubles as its carry-in.
    always_comb begin
        ctl_p[0]       = '0;
        ctl_p[0].valid = accept;
        ctl_p[0].sub   = sub;
        ctl_p[0].sat   = sat;
        ctl_p[0].carry = sub;
        ctl_p[0].a_msb = a[WIDTH-1];
        ctl_p[0].b_msb = b[WIDTH-1] ^ sub;
    end

    assign a_p[0]   = a;
    assign b_p[0]   = b;
    assign res_p[0] = '0;
    assign tag_p[0] = in_tag;

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        addsub_slice #(
            .WIDTH (WIDTH),
            .CHUNK (CHUNK),
            .TAG_W (TAG_W),
            .K     (k)
        ) u_slice (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (adv),
            .flush   (flush),
            .ctl_in  (ctl_p[k]),
            .a_in    (a_p[k]),
            .b_in    (b_p[k]),
            .res_in  (res_p[k]),
            .tag_in  (tag_p[k]),
            .ctl_out (ctl_p[k+1]),
            .a_out   (a_p[k+1]),
            .b_out   (b_p[k+1]),
            .res_out (res_p[k+1]),
            .tag_out (tag_p[k+1])
        );
    end

    // Output stage: overflow, saturation and flags from the final slice;
    // everything reads zero while the output slot is empty.
    always_comb begin
        fin       = ctl_p[STAGES];
        raw       = res_p[STAGES];
        ovf_raw   = (fin.a_msb == fin.b_msb) && (raw[WIDTH-1] != fin.a_msb);
        res_sat   = saturate(raw, fin.sat && ovf_raw, fin.a_msb);
        out_valid = fin.valid;
        result    = '0;
        ovf       = 1'b0;
        carry     = 1'b0;
        zero      = 1'b0;
        neg       = 1'b0;
        out_tag   = '0;
        if (fin.valid) begin
            result  = res_sat;
            ovf     = ovf_raw;
            carry   = fin.carry;
            zero    = (res_sat == '0);
            neg     = res_sat[WIDTH-1];
            out_tag = tag_p[STAGES];
        end
    end

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: three instances (32/4, 32/1, 16/2) share one
// stimulus stream. Directed vectors carry hand-computed 32-bit answers;
// the 16-bit instance is checked against an integer reference model.
module tb_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        sub = 1'b0;
    logic        sat = 1'b0;
    logic [3:0]  in_tag = '0;
    logic        out_ready = 1'b1;

    logic        rdy [3];
    logic        ov  [3];
    logic        of  [3];
    logic        cy  [3];
    logic        zr  [3];
    logic        ng  [3];
    logic [3:0]  tg  [3];
    logic [31:0] rs  [3];
    logic [31:0] res_s4, res_s1;
    logic [15:0] res_w16;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    addsub_pipe #(.WIDTH(32), .STAGES(4), .TAG_W(4)) u_s4 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy[0]),
        .a(a), .b(b), .sub(sub), .sat(sat), .in_tag(in_tag),
        .out_valid(ov[0]), .out_ready(out_ready), .result(res_s4), .ovf(of[0]),
        .carry(cy[0]), .zero(zr[0]), .neg(ng[0]), .out_tag(tg[0]));

    addsub_pipe #(.WIDTH(32), .STAGES(1), .TAG_W(4)) u_s1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy[1]),
        .a(a), .b(b), .sub(sub), .sat(sat), .in_tag(in_tag),
        .out_valid(ov[1]), .out_ready(out_ready), .result(res_s1), .ovf(of[1]),
        .carry(cy[1]), .zero(zr[1]), .neg(ng[1]), .out_tag(tg[1]));

    addsub_pipe #(.WIDTH(16), .STAGES(2), .TAG_W(4)) u_w16 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy[2]),
        .a(a[15:0]), .b(b[15:0]), .sub(sub), .sat(sat), .in_tag(in_tag),
        .out_valid(ov[2]), .out_ready(out_ready), .result(res_w16), .ovf(of[2]),
        .carry(cy[2]), .zero(zr[2]), .neg(ng[2]), .out_tag(tg[2]));

    always_comb begin
        rs[0] = res_s4;
        rs[1] = res_s1;
        rs[2] = {16'h0000, res_w16};
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        sat;
        logic [31:0] res;
        logic        o;
        logic        c;
        logic        z;
        logic        n;
    } vec_t;

    localparam int NV = 13;
    vec_t vt [NV];

    string dn [3] = '{"s4", "s1", "w16"};
    int    lat_exp [3] = '{4, 1, 2};
    int    width [3] = '{32, 32, 16};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: exact signed/unsigned integer arithmetic on w-bit operands.
    function automatic logic [31:0] model(input logic [31:0] ia, input logic [31:0] ib,
                                          input logic isub, input logic isat, input int w,
                                          output logic o, output logic c,
                                          output logic z, output logic n);
        longint mask, au, bu, sa, sb, ex, mx, mn;
        logic [31:0] r;
        mask = (64'sd1 <<< w) - 1;
        au = longint'(ia) & mask;
        bu = longint'(ib) & mask;
        mx = (64'sd1 <<< (w - 1)) - 1;
        mn = -(mx + 1);
        sa = (au > mx) ? au - (64'sd1 <<< w) : au;
        sb = (bu > mx) ? bu - (64'sd1 <<< w) : bu;
        ex = isub ? sa - sb : sa + sb;
        o  = (ex > mx) || (ex < mn);
        c  = isub ? (au >= bu) : ((au + bu) > mask);
        if (isat && o) r = 32'((ex > mx ? mx : mn) & mask);
        else           r = 32'(ex & mask);
        z = (r == 32'h0);
        n = r[w-1];
        return r;
    endfunction

    // Apply one op, then watch each instance for its single result.
    task automatic run_vec(input vec_t v, input int vi);
        logic        got [3];
        int          lat [3];
        logic [31:0] gr [3];
        logic        go [3], gc [3], gz [3], gn [3];
        logic [3:0]  gt [3];
        logic [31:0] er;
        logic        eo, ec, ez, en;
        for (int d = 0; d < 3; d++) begin
            got[d] = 1'b0; lat[d] = 0; gr[d] = '0; gt[d] = '0;
            go[d] = 1'b0; gc[d] = 1'b0; gz[d] = 1'b0; gn[d] = 1'b0;
        end
        in_valid = 1'b1; a = v.a; b = v.b; sub = v.sub; sat = v.sat; in_tag = 4'(vi);
        @(negedge clk);
        check($sformatf("v%0d.in_ready", vi), {31'b0, rdy[0] & rdy[1] & rdy[2]}, 32'h1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (ov[d] && !got[d]) begin
                    got[d] = 1'b1; lat[d] = cyc; gr[d] = rs[d]; gt[d] = tg[d];
                    go[d] = of[d]; gc[d] = cy[d]; gz[d] = zr[d]; gn[d] = ng[d];
                end
            end
            @(posedge clk); #1;
        end
        for (int d = 0; d < 3; d++) begin
            if (d < 2) begin
                er = v.res; eo = v.o; ec = v.c; ez = v.z; en = v.n;
            end else begin
                er = model(v.a, v.b, v.sub, v.sat, width[d], eo, ec, ez, en);
            end
            check($sformatf("v%0d.%s.latency", vi, dn[d]), lat[d], lat_exp[d]);
            check($sformatf("v%0d.%s.result", vi, dn[d]), gr[d], er);
            check($sformatf("v%0d.%s.ovf", vi, dn[d]), {31'b0, go[d]}, {31'b0, eo});
            check($sformatf("v%0d.%s.carry", vi, dn[d]), {31'b0, gc[d]}, {31'b0, ec});
            check($sformatf("v%0d.%s.zero", vi, dn[d]), {31'b0, gz[d]}, {31'b0, ez});
            check($sformatf("v%0d.%s.neg", vi, dn[d]), {31'b0, gn[d]}, {31'b0, en});
            check($sformatf("v%0d.%s.tag", vi, dn[d]), {28'b0, gt[d]}, {28'b0, 4'(vi)});
        end
    endtask

    // Eight back-to-back ops with the consumer stalled in cycles 6..9.
    task automatic run_stream();
        int   idx;
        int   exp_tag [3];
        logic stalled [3];
        logic [31:0] hold_r [3];
        logic [3:0]  hold_t [3];
        logic acc;
        idx = 0;
        for (int d = 0; d < 3; d++) begin
            exp_tag[d] = 0; stalled[d] = 1'b0; hold_r[d] = '0; hold_t[d] = '0;
        end
        for (int c = 0; c < 24; c++) begin
            out_ready = !(c >= 6 && c <= 9);
            if (idx < 8) begin
                in_valid = 1'b1; a = 32'(idx * 3); b = 32'd100;
                sub = 1'b0; sat = 1'b0; in_tag = 4'(idx);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (stalled[d]) begin
                    check($sformatf("stream.%s.hold_valid", dn[d]), {31'b0, ov[d]}, 32'h1);
                    check($sformatf("stream.%s.hold_result", dn[d]), rs[d], hold_r[d]);
                    check($sformatf("stream.%s.hold_tag", dn[d]), {28'b0, tg[d]}, {28'b0, hold_t[d]});
                end
                stalled[d] = 1'b0;
                if (ov[d]) begin
                    if (out_ready) begin
                        check($sformatf("stream.%s.tag", dn[d]), {28'b0, tg[d]}, 32'(exp_tag[d]));
                        check($sformatf("stream.%s.result", dn[d]), rs[d], 32'(exp_tag[d] * 3 + 100));
                        exp_tag[d]++;
                    end else begin
                        check($sformatf("stream.%s.stall_in_ready", dn[d]), {31'b0, rdy[d]}, 32'h0);
                        stalled[d] = 1'b1; hold_r[d] = rs[d]; hold_t[d] = tg[d];
                    end
                end
            end
            acc = in_valid && rdy[0];
            if (in_valid) begin
                check("stream.accept_agree", {30'b0, rdy[1] ^ rdy[0], rdy[2] ^ rdy[0]}, 32'h0);
            end
            @(posedge clk); #1;
            if (acc) idx++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("stream.%s.count", dn[d]), 32'(exp_tag[d]), 32'd8);
        end
    endtask

    // Three ops in flight, one-cycle flush, then a fresh op.
    task automatic run_flush();
        int first;
        int bad;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1; a = 32'(c); b = 32'd1; sub = 1'b0; sat = 1'b0; in_tag = 4'(10 + c);
            @(posedge clk); #1;
        end
        in_tag = 4'd13; flush = 1'b1;
        @(negedge clk);
        check("flush.in_ready", {31'b0, rdy[0]}, 32'h0);
        @(posedge clk); #1;
        flush = 1'b0; a = 32'd40; b = 32'd2; in_tag = 4'd9;
        @(negedge clk);
        check("flush.valid_cleared", {31'b0, ov[0]}, 32'h0);
        check("flush.ready_after", {31'b0, rdy[0]}, 32'h1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        first = 0; bad = 0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (ov[0]) begin
                if (tg[0] != 4'd9) bad++;
                else if (first == 0) begin
                    first = cyc;
                    check("flush.new_result", rs[0], 32'd42);
                end
            end
            @(posedge clk); #1;
        end
        check("flush.stale_outputs", 32'(bad), 32'd0);
        check("flush.new_latency", 32'(first), 32'd4);
    endtask

    // Asynchronous reset with two ops in flight.
    task automatic run_reset();
        int bad;
        in_valid = 1'b1; a = 32'd7; b = 32'd8; sub = 1'b0; sat = 1'b0; in_tag = 4'd1;
        @(posedge clk); #1;
        a = 32'd9; in_tag = 4'd2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("reset.s1_valid_before", {31'b0, ov[1]}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset.%s.valid", dn[d]), {31'b0, ov[d]}, 32'h0);
            check($sformatf("reset.%s.result", dn[d]), rs[d], 32'h0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) if (ov[d]) bad++;
        end
        check("reset.no_stale", 32'(bad), 32'd0);
        check("reset.in_ready", {31'b0, rdy[0]}, 32'h1);
        @(posedge clk); #1;
    endtask

    initial begin
        vt[0]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[1]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[2]  = '{32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h80000000, 1'b1, 1'b1, 1'b0, 1'b1};
        vt[3]  = '{32'h00000005, 32'h00000005, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0};
        vt[4]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0};
        vt[5]  = '{32'h00000000, 32'h00000001, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[6]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[7]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b1, 32'h80000000, 1'b1, 1'b1, 1'b0, 1'b1};
        vt[8]  = '{32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[10] = '{32'h10000000, 32'h20000000, 1'b1, 1'b0, 32'hF0000000, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[11] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[12] = '{32'h00FF00FF, 32'h00010001, 1'b0, 1'b0, 32'h01000100, 1'b0, 1'b0, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst.%s.valid", dn[d]), {31'b0, ov[d]}, 32'h0);
            check($sformatf("rst.%s.result", dn[d]), rs[d], 32'h0);
            check($sformatf("rst.%s.tag", dn[d]), {28'b0, tg[d]}, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst.%s.in_ready", dn[d]), {31'b0, rdy[d]}, 32'h1);
        end

        for (int i = 0; i < NV; i++) begin
            run_vec(vt[i], i);
        end
        run_stream();
        run_flush();
        run_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
